// File: rtl/disp_pkg.sv
// Shared types and constants for the BCD display controller.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Nibble code the downstream seven-segment decoder renders as an unlit digit.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Constant helper for the elaboration-time digit-capacity check.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/dabble_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decade.
module dabble_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Pure combinational add-3 correction.
  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) d_o = d_i + 4'd3;
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Signed binary sample to BCD display nibbles plus a minus-sign flag.
// A start in IDLE latches the sample; LOAD takes its magnitude, SHIFT runs one
// double-dabble step per cycle for WIDTH cycles, and the edge into DONE
// publishes digits/neg together with a one-cycle done pulse.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display_ctrl
  import disp_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  value,
  output logic [4*DIGITS-1:0]      digits,
  output logic                     neg,
  output logic                     busy,
  output logic                     done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // The display must hold the largest magnitude, 2^(WIDTH-1), without overflow.
  if (pow10(DIGITS) <= (64'd1 << (WIDTH - 1))) begin : g_range_err
    $error("bcd_display_ctrl: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic [BW-1:0]           digits_q;
  logic                    neg_q;

  logic [WIDTH-1:0]        val_q;
  logic [WIDTH-1:0]        bin_q;
  logic [BW-1:0]           bcd_q;

  logic [WIDTH-1:0]        mag;
  logic [BW-1:0]           bcd_adj;
  logic [BW+WIDTH-1:0]     shifted;
  logic                    last_shift;

`ifdef LEADING_ZERO_BLANK_EN
  // Replace zero digits above the most significant nonzero one with BLANK_CODE;
  // digit 0 is always shown so that zero displays as a single 0.
  function automatic logic [BW-1:0] fmt_digits(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          lead;
    r    = b;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (b[4*i +: 4] == 4'd0)) r[4*i +: 4] = BLANK_CODE;
      else                              lead = 1'b0;
    end
    return r;
  endfunction
`else
  // Every digit carries BCD, leading zeros included.
  function automatic logic [BW-1:0] fmt_digits(input logic [BW-1:0] b);
    return b;
  endfunction
`endif

  // Two's-complement magnitude; the most negative input maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  assign mag = val_q[WIDTH-1] ? ((~val_q) + 1'b1) : val_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    dabble_adj u_adj (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (bcd_adj[4*g +: 4])
    );
  end

  assign shifted    = {bcd_adj, bin_q} << 1;
  assign last_shift = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, step counter and the published display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      digits_q <= {DIGITS{BLANK_CODE}};
      neg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == LOAD)  cnt_q <= '0;
      if (state_q == SHIFT) cnt_q <= cnt_q + 1'b1;
      if (last_shift) begin
        digits_q <= fmt_digits(shifted[BW+WIDTH-1:WIDTH]);
        neg_q    <= val_q[WIDTH-1];
      end
    end
  end

  // Conversion datapath; contents only matter between LOAD and DONE.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) val_q <= value;
    if (state_q == LOAD) begin
      bin_q <= mag;
      bcd_q <= '0;
    end
    if (state_q == SHIFT) begin
      bcd_q <= shifted[BW+WIDTH-1:WIDTH];
      bin_q <= shifted[WIDTH-1:0];
    end
  end

  assign digits = digits_q;
  assign neg    = neg_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl with WIDTH=10, DIGITS=4.
module tb_bcd_display_ctrl;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic signed [9:0] value;
  logic [15:0]       digits;
  logic              neg;
  logic              busy;
  logic              done;

  int checks;
  int failures;

  logic [15:0] model_dig;
  logic        model_neg;

  bcd_display_ctrl #(.WIDTH(10), .DIGITS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .value  (value),
    .digits (digits),
    .neg    (neg),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Picks the expected display for the current build option.
  function automatic logic [15:0] sel(input logic [15:0] plain, input logic [15:0] blanked);
`ifdef LEADING_ZERO_BLANK_EN
    return blanked;
`else
    return plain;
`endif
  endfunction

  // Called #1 after a rising edge with the DUT idle. Edge 1 is the accepting edge;
  // done must be seen after edge 12 (WIDTH+2 edges from presenting start).
  task automatic convert(input logic signed [9:0] v, input logic [15:0] edig,
                         input logic eneg, input string tag);
    int lat;
    lat   = 0;
    value = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    for (int k = 2; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
      if (k == 6) begin
        chk({tag, " hold digits"}, 32'(digits), 32'(model_dig));
        chk({tag, " hold neg"}, 32'(neg), 32'(model_neg));
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'd12);
    chk({tag, " digits"}, 32'(digits), 32'(edig));
    chk({tag, " neg"}, 32'(neg), 32'(eneg));
    @(posedge clk); #1;
    chk({tag, " done width"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    model_dig = edig;
    model_neg = eneg;
  endtask

  initial begin
    int ndone;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    value    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst digits", 32'(digits), 32'hFFFF);
    chk("rst neg", 32'(neg), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    model_dig = 16'hFFFF;
    model_neg = 1'b0;
    @(posedge clk); #1;

    // Main conversions
    convert(10'sd345,  sel(16'h0345, 16'hF345), 1'b0, "pos345");
    convert(-10'sd512, sel(16'h0512, 16'hF512), 1'b1, "neg512");
    convert(10'sd0,    sel(16'h0000, 16'hFFF0), 1'b0, "zero");
    convert(-10'sd1,   sel(16'h0001, 16'hFFF1), 1'b1, "neg1");
    convert(10'sd511,  sel(16'h0511, 16'hF511), 1'b0, "pos511");

    // Start held through busy and DONE with a changed value: one conversion only
    value = 10'sd123;
    start = 1'b1;
    @(posedge clk); #1;
    value = 10'sd77;
    ndone = 0;
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk("held digits", 32'(digits), 32'(sel(16'h0123, 16'hF123)));
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("held one done", 32'(ndone), 32'd1);
    chk("held final digits", 32'(digits), 32'(sel(16'h0123, 16'hF123)));
    chk("held idle", 32'(busy), 32'd0);
    model_dig = sel(16'h0123, 16'hF123);
    model_neg = 1'b0;

    // Reset during the fifth SHIFT cycle
    value = 10'sd345;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst digits", 32'(digits), 32'hFFFF);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst neg", 32'(neg), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_dig = 16'hFFFF;
    model_neg = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst no done", 32'(ndone), 32'd0);
    chk("midrst still blank", 32'(digits), 32'hFFFF);

    convert(10'sd99, sel(16'h0099, 16'hFF99), 1'b0, "after rst 99");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 10: bit width of the signed input sample.
REQ-002 SHALL have parameter DIGITS, default 4: number of decimal digit nibbles driven.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port start, input, 1: request to convert and display value.
REQ-006 SHALL have port value, input, WIDTH: two's-complement sample.
REQ-007 SHALL have port digits, output, 4*DIGITS: BCD nibbles; digit 0 (units) at [3:0]; code 4'hF means blank.
REQ-008 SHALL have port neg, output, 1: minus-sign indicator for the displayed value.
REQ-009 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking a digits/neg update.

Function
REQ-011 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-012 SHALL accept start only in IDLE; the accepting edge latches value and moves to LOAD.
REQ-013 SHALL ignore start in LOAD, SHIFT and DONE, with no queuing.
REQ-014 LOAD SHALL compute the unsigned magnitude of the latched value in WIDTH bits, clear the BCD accumulator, and go to SHIFT.
REQ-015 SHIFT SHALL perform one double-dabble step per cycle for exactly WIDTH cycles.
- Each step adds 3 to every BCD digit >= 5, then shifts left one bit.
REQ-016 After the last shift, the state SHALL be DONE for exactly one cycle, then IDLE.
REQ-017 The edge entering DONE SHALL update digits and neg together, and done SHALL be high only during DONE.
- done is high in the cycle beginning WIDTH+2 edges after the accepting edge (12 for WIDTH=10).
REQ-018 digits and neg SHALL hold their previous values throughout a conversion.
REQ-019 The most negative input (-2^(WIDTH-1)) SHALL convert to magnitude 2^(WIDTH-1) without error.
REQ-020 neg SHALL be 1 only for a negative nonzero value.
REQ-021 Elaboration SHALL fail unless 10^DIGITS > 2^(WIDTH-1), so no magnitude overflow is possible.
REQ-022 start asserted in the DONE cycle SHALL be ignored; the earliest next accepting edge is the first edge in IDLE.

Reset
REQ-023 While rst_n is low, the block SHALL force: state IDLE, digits all 4'hF, neg 0, busy 0, done 0.
REQ-024 Reset mid-conversion SHALL abort the conversion with no done pulse and no digits update.
REQ-025 The first start after rst_n deasserts SHALL be processed normally.

Configuration
REQ-026 With LEADING_ZERO_BLANK_EN defined, digit nibbles above the most significant nonzero digit SHALL be 4'hF.
- A value of 0 shows only digit 0 as 4'h0.
REQ-027 Without LEADING_ZERO_BLANK_EN, all DIGITS nibbles SHALL carry BCD, including leading zeros.

Structure
REQ-028 Package disp_pkg SHALL hold the state enum typedef and the constant BLANK_CODE = 4'hF.
REQ-029 The per-digit add-3 correction SHALL be a combinational sub-module named dabble_adj, instantiated DIGITS times.
REQ-030 The block SHALL drive nibbles only; the board top connects each nibble to a seg7 decoder, which blanks for codes above 9.

Verification
REQ-031 Reset check: assert rst_n=0 -> digits=16'hFFFF, neg=0, busy=0, done=0.
REQ-032 Positive value: start with value=345 -> done exactly 12 cycles after acceptance.
- Without the macro: digits=16'h0345. With the macro: digits=16'hF345. neg=0 in both.
REQ-033 Most negative value: value=-512 -> digits=16'h0512, neg=1 (macro undefined).
REQ-034 Zero and ignored requests:
- value=0 -> digits=16'h0000 (no macro) or 16'hFFF0 (macro), neg=0.
- start held high during busy with value=77 -> exactly one done, display unchanged by 77.
REQ-035 Reset mid-conversion: rst_n low during cycle 5 of SHIFT -> digits blank, busy=0, no done.
- Then start with value=99 -> digits=16'h0099 (no macro).
